dft_power_acc: RTL and testbench
================================

DFT_POWER_ACC -- requirements
Module: dft_power_acc

Interface
REQ-001 SHALL have parameter DATA_IN_W, default 16, signed width of the real and imaginary bin inputs.
REQ-002 SHALL have parameter BINS_N, default 3, number of bins per DFT frame burst.
REQ-003 SHALL have parameter ACC_LOG2, default 4, averaging depth of 2^ACC_LOG2 frames.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports data_re_in and data_im_in, input, DATA_IN_W each, signed bin value from the DFT core.
REQ-007 SHALL have port valid_in, input, 1, asserted for BINS_N consecutive cycles per frame.
REQ-008 SHALL have port power_out, output, 2*DATA_IN_W, unsigned averaged power of one bin.
REQ-009 SHALL have port bin_idx_out, output, $clog2(BINS_N), index of the bin on power_out.
REQ-010 SHALL have port valid_out, output, 1, power_out is valid.
REQ-011 SHALL have port err_out, output, 1, sticky flag for a malformed input burst.

Function
REQ-012 SHALL compute p = re*re + im*im per input sample, unsigned, 2*DATA_IN_W bits; the maximum value (-2^15,-2^15) gives 2^31 and SHALL NOT overflow.
REQ-013 SHALL use a pipeline of square stage, sum stage and accumulate stage, so an input sample reaches its accumulator 3 cycles after it is accepted.
REQ-014 SHALL keep a bin counter that advances on each valid_in and wraps at BINS_N; one wrap completes one frame.
REQ-015 SHALL keep one accumulator per bin of 2*DATA_IN_W+ACC_LOG2 bits, plus a frame counter that wraps at 2^ACC_LOG2.
REQ-016 SHALL handle the final frame's last bin as follows: copy acc>>ACC_LOG2 of every bin into holding registers, and clear the accumulators and the frame counter in the same cycle.
REQ-017 SHALL implement an FSM with states IDLE, ACCUM and DUMP.
REQ-018 FSM transitions SHALL be: IDLE->ACCUM on the first valid_in; ACCUM->DUMP on the holding-register load; DUMP->ACCUM after BINS_N output cycles.
REQ-019 SHALL, in DUMP, assert valid_out for exactly BINS_N consecutive cycles with bin_idx_out = 0..BINS_N-1 in order.
REQ-020 SHALL continue accumulating the next frame's input during DUMP without loss, because the holding registers decouple output from accumulation.
REQ-021 SHALL treat valid_in deasserting while the bin counter is nonzero as a short burst, with these effects:
- set err_out;
- clear the bin counter, the frame counter and all accumulators;
- discard all in-flight pipeline data of that frame.
REQ-022 SHALL treat more than BINS_N consecutive valid_in cycles as back-to-back frames, with no error.
REQ-023 SHALL clear err_out only by reset.
REQ-024 SHALL hold power_out and bin_idx_out at their last value when valid_out is low.

Reset
REQ-025 SHALL, on rst_n low, immediately reset the following:
- power_out, bin_idx_out, valid_out and err_out to 0;
- all accumulators, holding registers, counters and pipeline valid bits to 0;
- the FSM to IDLE.
REQ-026 SHALL abort a DUMP interrupted by reset; no remaining valid_out pulses follow after rst_n returns high.

Configuration
REQ-027 SHALL, with macro DFT_POWER_PEAK_EN defined, add output peak_idx_out of $clog2(BINS_N) bits.
- peak_idx_out holds the index of the largest averaged bin power; the lowest index wins ties.
- It is valid on the cycle where the last bin of a DUMP has valid_out high, and resets to 0.
REQ-028 SHALL, without DFT_POWER_PEAK_EN, have no peak_idx_out port and no comparator logic.

Structure
REQ-029 SHALL place the default widths, BINS_N, ACC_LOG2 and the FSM state encoding in shared package dft_pkg.
REQ-030 SHALL instantiate sub-module dft_power_sq, a 2-stage pipelined re^2+im^2 with a valid pass-through.

Verification (ACC_LOG2=2, BINS_N=3)
REQ-031 SHALL cover: 4 frames of re=3, im=4 on all bins -> 3 valid_out cycles, power_out=25 with bin_idx 0,1,2, err_out=0.
REQ-032 SHALL cover: 4 frames of re=-32768, im=-32768 -> power_out=0x80000000 on all bins.
REQ-033 SHALL cover: frames with bin powers 100,400,900 on frame k and 0 on others -> power_out 25,100,225; with DFT_POWER_PEAK_EN, peak_idx_out=2.
REQ-034 SHALL cover: a 2-cycle burst then 4 good frames (re=1, im=0) -> err_out=1 held, and the output is exactly 1,1,1 from the 4 good frames only.
REQ-035 SHALL cover: the 5th frame arriving during DUMP -> dump values unchanged, and the next dump averages frames 5-8 correctly.
REQ-036 SHALL cover: rst_n pulsed low on the 2nd DUMP cycle -> all outputs 0 immediately, no further valid_out until 4 new frames complete.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared defaults and FSM encoding for the DFT bin power averager.
package dft_pkg;

    localparam int DATA_IN_W_DEF = 16;
    localparam int BINS_N_DEF    = 3;
    localparam int ACC_LOG2_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } state_e;

endpackage

// File: rtl/dft_power_sq.sv
// Two-stage pipelined re^2 + im^2 with a flushable valid pass-through.
module dft_power_sq
    import dft_pkg::*;
#(
    parameter int W = DATA_IN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic signed [W-1:0]   re_in,
    input  logic signed [W-1:0]   im_in,
    output logic                  valid_out,
    output logic [2*W-1:0]        pwr_out
);

    logic signed [2*W-1:0] re_x;
    logic signed [2*W-1:0] im_x;
    logic [2*W-1:0] re_sq_d, re_sq_q;
    logic [2*W-1:0] im_sq_d, im_sq_q;
    logic [2*W-1:0] sum_d, sum_q;
    logic v1_d, v1_q;
    logic v2_d, v2_q;

    // Squares are non-negative and at most 2^(2W-2), so the sum fits 2W bits.
    always_comb begin
        re_x    = {{W{re_in[W-1]}}, re_in};
        im_x    = {{W{im_in[W-1]}}, im_in};
        re_sq_d = $unsigned(re_x * re_x);
        im_sq_d = $unsigned(im_x * im_x);
        sum_d   = re_sq_q + im_sq_q;
        v1_d    = valid_in & ~flush;
        v2_d    = v1_q & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_sq_q <= '0;
            im_sq_q <= '0;
            sum_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            sum_q   <= sum_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
        end
    end

    assign valid_out = v2_q;
    assign pwr_out   = sum_q;

endmodule

// File: rtl/dft_power_acc.sv
// Per-bin power averaging over 2^ACC_LOG2 DFT frames with a holding-register dump.
// Define DFT_POWER_PEAK_EN to add peak_idx_out (index of the largest averaged bin).
module dft_power_acc
    import dft_pkg::*;
#(
    parameter int DATA_IN_W = DATA_IN_W_DEF,
    parameter int BINS_N    = BINS_N_DEF,
    parameter int ACC_LOG2  = ACC_LOG2_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_IN_W-1:0] data_re_in,
    input  logic signed [DATA_IN_W-1:0] data_im_in,
    input  logic                        valid_in,
    output logic [2*DATA_IN_W-1:0]      power_out,
    output logic [$clog2(BINS_N)-1:0]   bin_idx_out,
    output logic                        valid_out,
    output logic                        err_out
`ifdef DFT_POWER_PEAK_EN
    ,
    output logic [$clog2(BINS_N)-1:0]   peak_idx_out
`endif
);

    localparam int BW = $clog2(BINS_N);
    localparam int PW = 2 * DATA_IN_W;
    localparam int AW = PW + ACC_LOG2;
    localparam int FW = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
    localparam logic [BW-1:0] LAST_BIN = BW'(BINS_N - 1);
    localparam logic [FW-1:0] LAST_FRM = FW'((1 << ACC_LOG2) - 1);

    logic [BW-1:0] bin_cnt_d, bin_cnt_q;
    logic [BW-1:0] bin_s1_d, bin_s1_q;
    logic [BW-1:0] bin_s2_d, bin_s2_q;
    logic [FW-1:0] frm_d, frm_q;
    logic          err_d, err_q;
    logic          short_burst;
    logic          load;
    logic          sq_valid;
    logic [PW-1:0] sq_pwr;

    logic [AW-1:0] acc_nx [BINS_N];
    logic [AW-1:0] acc_d  [BINS_N];
    logic [AW-1:0] acc_q  [BINS_N];
    logic [PW-1:0] hold_d [BINS_N];
    logic [PW-1:0] hold_q [BINS_N];

    state_e        state_d, state_q;
    logic [BW-1:0] dump_d, dump_q;
    logic [PW-1:0] pwr_d, pwr_q;
    logic [BW-1:0] idx_d, idx_q;
    logic          vld_d, vld_q;

    dft_power_sq #(
        .W (DATA_IN_W)
    ) u_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (short_burst),
        .valid_in  (valid_in),
        .re_in     (data_re_in),
        .im_in     (data_im_in),
        .valid_out (sq_valid),
        .pwr_out   (sq_pwr)
    );

    always_comb begin
        short_burst = ~valid_in && (bin_cnt_q != '0);
        bin_cnt_d   = bin_cnt_q;
        if (short_burst) begin
            bin_cnt_d = '0;
        end else if (valid_in) begin
            bin_cnt_d = (bin_cnt_q == LAST_BIN) ? '0 : bin_cnt_q + BW'(1);
        end
        bin_s1_d = bin_cnt_q;
        bin_s2_d = bin_s1_q;
        err_d    = err_q | short_burst;
    end

    // The final frame's last sample is folded in on the same cycle it is dumped.
    always_comb begin
        load  = sq_valid && (bin_s2_q == LAST_BIN) &&
                (frm_q == LAST_FRM) && !short_burst;
        frm_d = frm_q;
        if (short_burst) begin
            frm_d = '0;
        end else if (sq_valid && bin_s2_q == LAST_BIN) begin
            frm_d = (frm_q == LAST_FRM) ? '0 : frm_q + FW'(1);
        end
        for (int b = 0; b < BINS_N; b++) begin
            acc_nx[b] = acc_q[b];
            if (sq_valid && bin_s2_q == BW'(b)) begin
                acc_nx[b] = acc_q[b] + AW'(sq_pwr);
            end
            hold_d[b] = load ? acc_nx[b][ACC_LOG2 +: PW] : hold_q[b];
            acc_d[b]  = (short_burst || load) ? '0 : acc_nx[b];
        end
    end

    always_comb begin
        state_d = state_q;
        dump_d  = dump_q;
        vld_d   = 1'b0;
        pwr_d   = pwr_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_in) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (load) begin
                    state_d = ST_DUMP;
                    dump_d  = '0;
                end
            end
            ST_DUMP: begin
                vld_d = 1'b1;
                pwr_d = hold_q[dump_q];
                idx_d = dump_q;
                if (dump_q == LAST_BIN) begin
                    state_d = ST_ACCUM;
                    dump_d  = '0;
                end else begin
                    dump_d = dump_q + BW'(1);
                end
                // Very short averaging depths can reload mid-dump.
                if (load) begin
                    state_d = ST_DUMP;
                    dump_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt_q <= '0;
            bin_s1_q  <= '0;
            bin_s2_q  <= '0;
            frm_q     <= '0;
            err_q     <= 1'b0;
            state_q   <= ST_IDLE;
            dump_q    <= '0;
            pwr_q     <= '0;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            for (int b = 0; b < BINS_N; b++) begin
                acc_q[b]  <= '0;
                hold_q[b] <= '0;
            end
        end else begin
            bin_cnt_q <= bin_cnt_d;
            bin_s1_q  <= bin_s1_d;
            bin_s2_q  <= bin_s2_d;
            frm_q     <= frm_d;
            err_q     <= err_d;
            state_q   <= state_d;
            dump_q    <= dump_d;
            pwr_q     <= pwr_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            for (int b = 0; b < BINS_N; b++) begin
                acc_q[b]  <= acc_d[b];
                hold_q[b] <= hold_d[b];
            end
        end
    end

    assign power_out   = pwr_q;
    assign bin_idx_out = idx_q;
    assign valid_out   = vld_q;
    assign err_out     = err_q;

`ifdef DFT_POWER_PEAK_EN
    logic [BW-1:0] peak_d, peak_q;
    logic [BW-1:0] best_idx;
    logic [PW-1:0] best_pwr;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_pwr = hold_q[0];
        for (int b = 1; b < BINS_N; b++) begin
            if (hold_q[b] > best_pwr) begin
                best_pwr = hold_q[b];
                best_idx = BW'(b);
            end
        end
        peak_d = peak_q;
        if (state_q == ST_DUMP && dump_q == LAST_BIN) peak_d = best_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) peak_q <= '0;
        else        peak_q <= peak_d;
    end

    assign peak_idx_out = peak_q;
`endif

endmodule

// File: tb/tb_dft_power_acc.sv
// Directed bench for dft_power_acc (BINS_N=3, ACC_LOG2=2).
module tb_dft_power_acc;

    localparam int W  = 16;
    localparam int BN = 3;
    localparam int AL = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic signed [W-1:0] re = '0;
    logic signed [W-1:0] im = '0;
    logic                vin = 1'b0;
    logic [2*W-1:0]      power_out;
    logic [1:0]          bin_idx_out;
    logic                valid_out;
    logic                err_out;
`ifdef DFT_POWER_PEAK_EN
    logic [1:0]          peak_idx_out;
`endif

    always #5 clk = ~clk;

    dft_power_acc #(
        .DATA_IN_W (W),
        .BINS_N    (BN),
        .ACC_LOG2  (AL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_re_in   (re),
        .data_im_in   (im),
        .valid_in     (vin),
        .power_out    (power_out),
        .bin_idx_out  (bin_idx_out),
        .valid_out    (valid_out),
        .err_out      (err_out)
`ifdef DFT_POWER_PEAK_EN
        ,
        .peak_idx_out (peak_idx_out)
`endif
    );

    typedef struct packed {
        logic [31:0] pwr;
        logic [1:0]  idx;
        logic [1:0]  peak;
        logic [31:0] cyc;
    } obs_t;

    typedef struct packed {
        logic [2:0][15:0] re;
        logic [2:0][15:0] im;
        logic [2:0]       hot;
        logic [2:0][31:0] exp;
        logic [1:0]       peak;
    } vec_t;

    obs_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        cyc++;
        if (valid_out) begin
`ifdef DFT_POWER_PEAK_EN
            q.push_back('{power_out, bin_idx_out, peak_idx_out, 32'(cyc)});
`else
            q.push_back('{power_out, bin_idx_out, 2'd0, 32'(cyc)});
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r0, input int r1, input int r2,
                                input int i0, input int i1, input int i2,
                                input int hot, input int e0, input int e1,
                                input int e2, input int pk);
        vec_t v;
        v.re[0] = 16'(r0); v.re[1] = 16'(r1); v.re[2] = 16'(r2);
        v.im[0] = 16'(i0); v.im[1] = 16'(i1); v.im[2] = 16'(i2);
        v.hot = 3'(hot);
        v.exp[0] = 32'(e0); v.exp[1] = 32'(e1); v.exp[2] = 32'(e2);
        v.peak = 2'(pk);
        return v;
    endfunction

    task automatic send_frame(input logic [2:0][15:0] r, input logic [2:0][15:0] i);
        for (int b = 0; b < BN; b++) begin
            re  = r[b];
            im  = i[b];
            vin = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_flat(input int r, input int i, input int nf);
        logic [2:0][15:0] rr, ii;
        for (int b = 0; b < BN; b++) begin
            rr[b] = 16'(r);
            ii[b] = 16'(i);
        end
        for (int f = 0; f < nf; f++) send_frame(rr, ii);
        vin = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("out_count", 32'(q.size()), 32'(n));
    endtask

    task automatic do_reset();
        vin   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t vt [5];
    logic [2:0][15:0] zr;
    bit   hit;

    initial begin
        zr = '0;
        vt[0] = mk(3, 3, 3, 4, 4, 4, 4, 25, 25, 25, 0);
        vt[1] = mk(-32768, -32768, -32768, -32768, -32768, -32768, 4,
                   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0);
        vt[2] = mk(10, 20, 30, 0, 0, 0, 1, 25, 100, 225, 2);
        vt[3] = mk(2, 3, 5, 0, 1, 1, 3, 1, 2, 6, 2);
        vt[4] = mk(1, 9, 9, 0, 0, 0, 4, 1, 81, 81, 1);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_power", power_out, 0);
        chk("rst_idx", 32'(bin_idx_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_err", 32'(err_out), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            q.delete();
            for (int f = 0; f < 4; f++) begin
                if (vt[v].hot == 3'd4 || vt[v].hot == 3'(f))
                    send_frame(vt[v].re, vt[v].im);
                else
                    send_frame(zr, zr);
            end
            vin = 1'b0;
            wait_out(3, 40);
            if (q.size() == 3) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("v%0d_pwr%0d", v, i), q[i].pwr, vt[v].exp[i]);
                    chk($sformatf("v%0d_idx%0d", v, i), 32'(q[i].idx), 32'(i));
                end
                chk($sformatf("v%0d_contig", v), q[2].cyc - q[0].cyc, 2);
`ifdef DFT_POWER_PEAK_EN
                chk($sformatf("v%0d_peak", v), 32'(q[2].peak), 32'(vt[v].peak));
`endif
            end
            chk($sformatf("v%0d_err", v), 32'(err_out), 0);
            repeat (3) @(posedge clk);
            #1;
        end

        // Short burst after two partial-average frames.
        do_reset();
        q.delete();
        send_flat(50, 0, 2);
        re = 100; im = 0; vin = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        vin = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("burst_err", 32'(err_out), 1);
        send_flat(1, 0, 2);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("burst_no_early", 32'(q.size()), 0);
        send_flat(1, 0, 2);
        wait_out(3, 40);
        if (q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("burst_pwr%0d", i), q[i].pwr, 1);
                chk($sformatf("burst_idx%0d", i), 32'(q[i].idx), 32'(i));
            end
        end
        chk("burst_err_held", 32'(err_out), 1);
        do_reset();
        chk("err_cleared_by_rst", 32'(err_out), 0);

        // Frame 5 arrives while the first dump is streaming out.
        q.delete();
        send_flat(3, 4, 4);
        vin = 1'b1;
        send_flat(6, 8, 4);
        wait_out(6, 80);
        if (q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("ovl_pwr%0d", i), q[i].pwr, (i < 3) ? 25 : 100);
                chk($sformatf("ovl_idx%0d", i), 32'(q[i].idx), 32'(i % 3));
            end
        end

        // Reset during the second dump cycle.
        do_reset();
        q.delete();
        send_flat(1, 1, 4);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk); #2;
            if (valid_out && bin_idx_out == 2'd1) hit = 1'b1;
        end
        chk("dump2_seen", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_power", power_out, 0);
        chk("mid_rst_idx", 32'(bin_idx_out), 0);
        chk("mid_rst_valid", 32'(valid_out), 0);
        chk("mid_rst_err", 32'(err_out), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        q.delete();
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("no_valid_after_rst", 32'(q.size()), 0);
        send_flat(2, 0, 4);
        wait_out(3, 40);
        if (q.size() == 3) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("post_rst_pwr%0d", i), q[i].pwr, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
